// File: rtl/div_job_arbiter.sv
// Two-port front end for a shared restoring divider: round-robin job intake,
// divider sequencing with a per-job watchdog, and a tagged response channel.
module div_job_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_x,
    input  logic [2*WIDTH-1:0] req_y,
    output logic               div_go,
    output logic [WIDTH-1:0]   div_x,
    output logic [WIDTH-1:0]   div_y,
    input  logic               div_done,
    input  logic               div_err,
    input  logic [WIDTH-1:0]   div_q,
    input  logic [WIDTH-1:0]   div_r,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_q,
    output logic [WIDTH-1:0]   rsp_r,
    output logic               rsp_err,
    output logic               rsp_tmo
);
    // state | meaning
    // IDLE  | offering a grant, waiting for a job handshake
    // LOAD  | operands registered, div_go pulsed, watchdog cleared
    // WAIT  | divider busy; watchdog counting toward TIMEOUT
    // RESP  | response presented until the consumer accepts it
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_grant;
    logic [TW-1:0] wdog;
    logic [1:0]    grant;
    logic          accept;
    logic          acc_id;
    logic          wdog_expired;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Gated by rst so a requester holding valid cannot see ready while reset is asserted.
    assign req_ready    = (state == IDLE && rst) ? grant : 2'b00;
    assign accept       = |req_ready;
    assign acc_id       = req_ready[1];
    assign wdog_expired = (wdog == TW'(TIMEOUT - 1));
    assign div_go       = (state == LOAD);
    assign rsp_valid    = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (div_err || div_done || wdog_expired) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wdog       <= '0;
            div_x      <= '0;
            div_y      <= '0;
            rsp_id     <= 1'b0;
            rsp_q      <= '0;
            rsp_r      <= '0;
            rsp_err    <= 1'b0;
            rsp_tmo    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_x      <= acc_id ? req_x[WIDTH +: WIDTH] : req_x[0 +: WIDTH];
                        div_y      <= acc_id ? req_y[WIDTH +: WIDTH] : req_y[0 +: WIDTH];
                        rsp_id     <= acc_id;
                        last_grant <= acc_id;
                    end
                end
                LOAD: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + TW'(1);
                    // Error beats done; either pulse beats the watchdog on the same cycle.
                    if (div_err) begin
                        rsp_err <= 1'b1;
                        rsp_tmo <= 1'b0;
                        rsp_q   <= '0;
                        rsp_r   <= '0;
                    end else if (div_done) begin
                        rsp_err <= 1'b0;
                        rsp_tmo <= 1'b0;
                        rsp_q   <= div_q;
                        rsp_r   <= div_r;
                    end else if (wdog_expired) begin
                        rsp_err <= 1'b1;
                        rsp_tmo <= 1'b1;
                        rsp_q   <= '0;
                        rsp_r   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_job_arbiter.sv
// Directed bench for div_job_arbiter; the divider is played by hand with
// precomputed quotient/remainder pulses.
module tb_div_job_arbiter;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [7:0]   req_x;
    logic [7:0]   req_y;
    logic         div_go;
    logic [3:0]   div_x;
    logic [3:0]   div_y;
    logic         div_done;
    logic         div_err;
    logic [3:0]   div_q;
    logic [3:0]   div_r;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [3:0]   rsp_q;
    logic [3:0]   rsp_r;
    logic         rsp_err;
    logic         rsp_tmo;

    int errors = 0;
    int checks = 0;

    div_job_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .div_go(div_go), .div_x(div_x), .div_y(div_y),
        .div_done(div_done), .div_err(div_err), .div_q(div_q), .div_r(div_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; req_valid = 2'b00; req_x = '0; req_y = '0;
        div_done = 1'b0; div_err = 1'b0; div_q = '0; div_r = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready);
        end
        checks++;
        if ({div_go, div_x, div_y} !== 9'd0) begin
            errors++; $display("FAIL reset_div got=%h exp=0", {div_go, div_x, div_y});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r} !== 12'd0) begin
            errors++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        req_x = {4'd0, 4'd13}; req_y = {4'd0, 4'd3}; req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got=%b exp=01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({div_go, div_x, div_y, req_ready} !== {1'b1, 4'd13, 4'd3, 2'b00}) begin
            errors++; $display("FAIL single_go got=%h exp=%h", {div_go, div_x, div_y, req_ready}, {1'b1, 4'd13, 4'd3, 2'b00});
        end
        @(negedge clk);
        checks++;
        if (div_go !== 1'b0) begin
            errors++; $display("FAIL single_go_width got=%b exp=0", div_go);
        end
        @(negedge clk);
        div_done = 1'b1; div_q = 4'd4; div_r = 4'd1;
        @(negedge clk);
        div_done = 1'b0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r} !== {4'b1000, 4'd4, 4'd1}) begin
            errors++; $display("FAIL single_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r}, {4'b1000, 4'd4, 4'd1});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_rsp_clear got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready;
        logic [3:0] exp_x, exp_q, exp_r;
        rst = 1'b0;
        req_x = {4'd7, 4'd8}; req_y = {4'd2, 4'd2}; req_valid = 2'b11;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_x     = (i % 2 == 0) ? 4'd8 : 4'd7;
            exp_q     = (i % 2 == 0) ? 4'd4 : 4'd3;
            exp_r     = (i % 2 == 0) ? 4'd0 : 4'd1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rr_grant job=%0d got=%b exp=%b", i, req_ready, exp_ready);
            end
            @(negedge clk);
            checks++;
            if ({div_go, div_x} !== {1'b1, exp_x}) begin
                errors++; $display("FAIL rr_go job=%0d got=%h exp=%h", i, {div_go, div_x}, {1'b1, exp_x});
            end
            @(negedge clk);
            div_done = 1'b1; div_q = exp_q; div_r = exp_r;
            @(negedge clk);
            div_done = 1'b0;
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_q, rsp_r} !== {1'b1, exp_ready[1], 1'b0, exp_q, exp_r}) begin
                errors++; $display("FAIL rr_rsp job=%0d got=%h exp=%h", i, {rsp_valid, rsp_id, rsp_err, rsp_q, rsp_r}, {1'b1, exp_ready[1], 1'b0, exp_q, exp_r});
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_div_err();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_x = {4'd9, 4'd0}; req_y = {4'd0, 4'd0}; req_valid = 2'b10;
            #1;
            checks++;
            if (req_ready !== 2'b10) begin
                errors++; $display("FAIL err_grant pass=%0d got=%b exp=10", k, req_ready);
            end
            @(negedge clk);
            req_valid = 2'b00;
            checks++;
            if ({div_go, div_x, div_y} !== {1'b1, 4'd9, 4'd0}) begin
                errors++; $display("FAIL err_go pass=%0d got=%h exp=%h", k, {div_go, div_x, div_y}, {1'b1, 4'd9, 4'd0});
            end
            @(negedge clk);
            div_err = 1'b1; div_done = (k == 1); div_q = 4'd5; div_r = 4'd5;
            @(negedge clk);
            div_err = 1'b0; div_done = 1'b0;
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r} !== {4'b1110, 4'd0, 4'd0}) begin
                errors++; $display("FAIL err_rsp pass=%0d got=%h exp=%h", k, {rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r}, {4'b1110, 4'd0, 4'd0});
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk);
        req_x = {4'd0, 4'd5}; req_y = {4'd0, 4'd1}; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (div_go !== 1'b1) begin
            errors++; $display("FAIL tmo_go got=%b exp=1", div_go);
        end
        n = 0;
        while (n < 200 && rsp_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        // n counts the LOAD->WAIT edge plus every WAIT cycle
        checks++;
        if (n !== TIMEOUT + 1) begin
            errors++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TIMEOUT + 1);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_tmo, rsp_q, rsp_r} !== {3'b111, 4'd0, 4'd0}) begin
            errors++; $display("FAIL tmo_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_tmo, rsp_q, rsp_r}, {3'b111, 4'd0, 4'd0});
        end
        div_done = 1'b1; div_q = 4'd7; div_r = 4'd7;
        @(negedge clk);
        div_done = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_tmo, rsp_q, rsp_r} !== {3'b111, 4'd0, 4'd0}) begin
            errors++; $display("FAIL tmo_late_done got=%h exp=%h", {rsp_valid, rsp_err, rsp_tmo, rsp_q, rsp_r}, {3'b111, 4'd0, 4'd0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (TIMEOUT) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_early got=%b exp=0", rsp_valid);
        end
        div_done = 1'b1; div_q = 4'd5; div_r = 4'd0;
        @(negedge clk);
        div_done = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_tmo, rsp_q, rsp_r} !== {3'b100, 4'd5, 4'd0}) begin
            errors++; $display("FAIL tmo_last_cycle_done got=%h exp=%h", {rsp_valid, rsp_err, rsp_tmo, rsp_q, rsp_r}, {3'b100, 4'd5, 4'd0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req_x = {4'd2, 4'd15}; req_y = {4'd1, 4'd4}; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        div_done = 1'b1; div_q = 4'd3; div_r = 4'd3;
        @(negedge clk);
        div_done = 1'b0;
        req_valid = 2'b10;
        #1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r, req_ready} !== {4'b1000, 4'd3, 4'd3, 2'b00}) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h", c, {rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r, req_ready}, {4'b1000, 4'd3, 4'd3, 2'b00});
            end
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin
            errors++; $display("FAIL bp_release got=%b exp=010", {rsp_valid, req_ready});
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        req_x = {4'd1, 4'd6}; req_y = {4'd1, 4'd3}; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, div_go, div_x, div_y} !== 11'd0) begin
            errors++; $display("FAIL rst_mid_div got=%h exp=0", {req_ready, div_go, div_x, div_y});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r} !== 12'd0) begin
            errors++; $display("FAIL rst_mid_rsp got=%h exp=0", {rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_mid_pointer got=%b exp=01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({div_go, div_x, div_y} !== {1'b1, 4'd6, 4'd3}) begin
            errors++; $display("FAIL rst_mid_go got=%h exp=%h", {div_go, div_x, div_y}, {1'b1, 4'd6, 4'd3});
        end
        @(negedge clk);
        div_done = 1'b1; div_q = 4'd2; div_r = 4'd0;
        @(negedge clk);
        div_done = 1'b0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r} !== {4'b1000, 4'd2, 4'd0}) begin
            errors++; $display("FAIL rst_mid_rsp_after got=%h exp=%h", {rsp_valid, rsp_id, rsp_err, rsp_tmo, rsp_q, rsp_r}, {4'b1000, 4'd2, 4'd0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_div_err();
        test_timeout();
        test_backpressure();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached without finishing");
        $fatal(1);
    end
endmodule
